// File: rtl/fewcore_mem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t     : responder FSM state encoding
//   WORD_BYTES  : bytes per data word (also the strobe width)
//   addr_err()  : misaligned / out-of-range check for a byte address
package fewcore_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

    // True when the byte address is not word aligned or its word index
    // falls outside the RAM.
    function automatic logic addr_err(input logic [31:0] addr,
                                      input logic [31:0] depth_words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bus between the core (master) and the
// responder (slave).
//   req_valid/req_ready     request handshake
//   req_write               1 = store, 0 = load
//   req_addr/req_wdata      byte address and store data
//   req_wstrb               byte enables (only with DMEM_WSTRB_EN defined)
//   resp_valid/resp_ready   response handshake
//   resp_rdata/resp_err     load data and error flag
interface dmem_responder_if;
    import fewcore_mem_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
`ifdef DMEM_WSTRB_EN
    logic [WORD_BYTES-1:0] req_wstrb;
`endif
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_err;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
`ifdef DMEM_WSTRB_EN
        input  req_wstrb,
`endif
        input  resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
`ifdef DMEM_WSTRB_EN
        output req_wstrb,
`endif
        output resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables. Writes are synchronous;
// the read port is a combinational index so the owning FSM can register the
// word on the same edge it performs the access. Contents are not reset.
//   clk      rising-edge clock
//   i_we     per-byte write enable
//   i_idx    word index
//   i_wdata  write data
//   o_rdata  read data at i_idx
module dmem_array
    import fewcore_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 10
) (
    input  logic                  clk,
    input  logic [WORD_BYTES-1:0] i_we,
    input  logic [IDX_W-1:0]      i_idx,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (i_we[b]) begin
                r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    // Non-power-of-two depths leave unused index codes; they read as zero.
    assign o_rdata = (int'(i_idx) < DEPTH_WORDS) ? r_mem[i_idx] : '0;

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the core's data-memory interface. Accepts one load/store,
// waits LATENCY cycles, performs the word access on an internal RAM and holds
// the response until the core takes it.
//   clk     rising-edge clock
//   reset   asynchronous, active-high reset
//   bus     dmem_responder_if.slave (request/response handshake)
// Build option: DMEM_WSTRB_EN adds req_wstrb and byte-masked stores;
// without it every store writes the full word.
module dmem_responder
    import fewcore_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int DATA_W      = 32
) (
    input  logic               clk,
    input  logic               reset,
    dmem_responder_if.slave    bus
);

    localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [31:0] DEPTH_L  = 32'(DEPTH_WORDS);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic                  r_write;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
`ifdef DMEM_WSTRB_EN
    logic [WORD_BYTES-1:0] r_wstrb;
`endif
    logic [31:0]           r_rdata;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_access;
    logic                  w_direct;
    logic                  w_acc_write;
    logic [31:0]           w_acc_addr;
    logic [31:0]           w_acc_wdata;
    logic [WORD_BYTES-1:0] w_acc_strb;
    logic                  w_acc_err;
    logic [WORD_BYTES-1:0] w_we;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_W-1:0]     w_ram_rdata;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    if (LATENCY == 1) begin
                        w_access    = 1'b1;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_access    = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // With LATENCY==1 the access happens on the accept edge, so it must use
    // the live request fields rather than the (not yet loaded) latches.
    assign w_direct    = (r_state == ST_IDLE);
    assign w_acc_write = w_direct ? bus.req_write : r_write;
    assign w_acc_addr  = w_direct ? bus.req_addr  : r_addr;
    assign w_acc_wdata = w_direct ? bus.req_wdata : r_wdata;
`ifdef DMEM_WSTRB_EN
    assign w_acc_strb  = w_direct ? bus.req_wstrb : r_wstrb;
`else
    assign w_acc_strb  = '1;
`endif

    assign w_acc_err = addr_err(w_acc_addr, DEPTH_L);
    assign w_idx     = w_acc_addr[IDX_W+1:2];
    assign w_we      = (w_access && w_acc_write && !w_acc_err) ? w_acc_strb : '0;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_W      (DATA_W),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_idx   (w_idx),
        .i_wdata (w_acc_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
`ifdef DMEM_WSTRB_EN
            r_wstrb <= '0;
`endif
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept) begin
                r_write <= bus.req_write;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
`ifdef DMEM_WSTRB_EN
                r_wstrb <= bus.req_wstrb;
`endif
                r_cnt   <= CNT_LOAD;
            end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_access) begin
                r_err   <= w_acc_err;
                r_rdata <= (w_acc_err || w_acc_write) ? 32'd0 : w_ram_rdata;
            end else if (r_state == ST_RESP && bus.resp_ready) begin
                r_err   <= 1'b0;
                r_rdata <= 32'd0;
            end
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.resp_valid = (r_state == ST_RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder_if b0 ();
    dmem_responder_if b1 ();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3), .DATA_W(32)) u_dut_l3 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .DATA_W(32)) u_dut_l1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    // Reference model: one word array per instance, plus the latency each
    // instance was built with.
    logic [31:0] mdl [2][DEPTH];
    int          lat [2] = '{3, 1};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_access(input int idx, input logic w, input logic [31:0] a,
                                         input logic [31:0] d, input logic [3:0] s,
                                         output logic e, output logic [31:0] rd);
        logic [3:0] es;
        int         wi;
`ifdef DMEM_WSTRB_EN
        es = s;
`else
        es = s | 4'hF;   // full-word store regardless of strobe
`endif
        e  = (a % 4 != 0) || ((a / 4) >= DEPTH);
        rd = 32'd0;
        if (!e) begin
            wi = int'(a / 4);
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (es[b]) mdl[idx][wi][8*b +: 8] = d[8*b +: 8];
            end else begin
                rd = mdl[idx][wi];
            end
        end
    endfunction

    task automatic drive_req(input int idx, input logic v, input logic w,
                             input logic [31:0] a, input logic [31:0] d);
        if (idx == 0) begin
            b0.req_valid = v; b0.req_write = w; b0.req_addr = a; b0.req_wdata = d;
        end else begin
            b1.req_valid = v; b1.req_write = w; b1.req_addr = a; b1.req_wdata = d;
        end
    endtask

    task automatic set_rready(input int idx, input logic v);
        if (idx == 0) b0.resp_ready = v;
        else          b1.resp_ready = v;
    endtask

    function automatic void sample(input int idx, output logic rv, output logic rq,
                                   output logic [31:0] rd, output logic re);
        if (idx == 0) begin
            rv = b0.resp_valid; rq = b0.req_ready; rd = b0.resp_rdata; re = b0.resp_err;
        end else begin
            rv = b1.resp_valid; rq = b1.req_ready; rd = b1.resp_rdata; re = b1.resp_err;
        end
    endfunction

    // Called just after a falling edge with the instance idle or about to be.
    task automatic do_txn(input int idx, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s, input int delay,
                          input logic keep_valid, output int acc_wait);
        logic        e_exp, rv, rq, re, re0;
        logic [31:0] rd_exp, rd, rd0;
        int          n;
        drive_req(idx, 1'b1, w, a, d);
`ifdef DMEM_WSTRB_EN
        if (idx == 0) b0.req_wstrb = s;
        else          b1.req_wstrb = s;
`endif
        acc_wait = 0;
        sample(idx, rv, rq, rd, re);
        while (!rq && acc_wait < 50) begin
            @(negedge clk);
            acc_wait++;
            sample(idx, rv, rq, rd, re);
        end
        if (!rq) begin
            check_val("accept_timeout", 32'(rq), 32'd1);
            drive_req(idx, 1'b0, 1'b0, 32'd0, 32'd0);
            return;
        end
        model_access(idx, w, a, d, s, e_exp, rd_exp);
        @(negedge clk);
        if (keep_valid) drive_req(idx, 1'b1, 1'b0, 32'd0, 32'd0);
        else            drive_req(idx, 1'b0, 1'b0, 32'd0, 32'd0);
        n = 1;
        sample(idx, rv, rq, rd, re);
        while (!rv && n < 50) begin
            @(negedge clk);
            n++;
            sample(idx, rv, rq, rd, re);
        end
        check_val("latency", 32'(n), 32'(lat[idx]));
        check_val("resp_err", 32'(re), 32'(e_exp));
        check_val("resp_rdata", rd, rd_exp);
        rd0 = rd;
        re0 = re;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            sample(idx, rv, rq, rd, re);
            check_val("hold_valid", 32'(rv), 32'd1);
            check_val("hold_rdata", rd, rd0);
            check_val("hold_err", 32'(re), 32'(re0));
            check_val("hold_req_ready", 32'(rq), 32'd0);
        end
        set_rready(idx, 1'b1);
        @(negedge clk);
        set_rready(idx, 1'b0);
        sample(idx, rv, rq, rd, re);
        check_val("post_valid", 32'(rv), 32'd0);
        check_val("post_req_ready", 32'(rq), 32'd1);
        check_val("post_rdata", rd, 32'd0);
        check_val("post_err", 32'(re), 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0)      return 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
        else if (r == 1) return 32'((DEPTH + $urandom_range(0, 63)) * 4);
        else if (r == 2) return 32'hFFFF_FFF0;
        else             return 32'($urandom_range(0, 63) * 4);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_errors %0d", n_errors);
        $fatal(1);
    end

    initial begin
        logic        rv, rq, re;
        logic [31:0] rd;
        int          aw, aw2, na, nr, guard;
        int          acc_cyc [4];
        logic [31:0] b2b_addr [4];
        logic [31:0] exp_q [$];
        logic        e_tmp;
        logic [31:0] rd_tmp;

        b2b_addr = '{32'h0, 32'hC, 32'h18, 32'h24};
        for (int i = 0; i < 2; i++) begin
            drive_req(i, 1'b0, 1'b0, 32'd0, 32'd0);
            set_rready(i, 1'b0);
        end
`ifdef DMEM_WSTRB_EN
        b0.req_wstrb = 4'h0;
        b1.req_wstrb = 4'h0;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            sample(i, rv, rq, rd, re);
            check_val("rst_req_ready", 32'(rq), 32'd1);
            check_val("rst_resp_valid", 32'(rv), 32'd0);
            check_val("rst_rdata", rd, 32'd0);
            check_val("rst_err", 32'(re), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Preload the low 64 words of both RAMs so later loads are defined.
        for (int i = 0; i < 2; i++)
            for (int wd = 0; wd < 64; wd++)
                do_txn(i, 1'b1, 32'(wd * 4), $urandom, 4'hF, 0, 1'b0, aw);

        // Latency on the LATENCY=3 instance
        do_txn(0, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, aw);
        do_txn(0, 1'b0, 32'h40, 32'd0, 4'h0, 0, 1'b0, aw);

        // Errors: misaligned load, out-of-range store must not alias word 0
        do_txn(0, 1'b0, 32'h41, 32'd0, 4'h0, 0, 1'b0, aw);
        do_txn(0, 1'b1, 32'(DEPTH * 4), 32'h5555_AAAA, 4'hF, 0, 1'b0, aw);
        do_txn(0, 1'b0, 32'h0, 32'd0, 4'h0, 0, 1'b0, aw);

        // Byte strobes
        do_txn(0, 1'b1, 32'h8, 32'h1122_3344, 4'hF, 0, 1'b0, aw);
        do_txn(0, 1'b1, 32'h8, 32'hAABB_CCDD, 4'b0101, 0, 1'b0, aw);
        do_txn(0, 1'b0, 32'h8, 32'd0, 4'h0, 0, 1'b0, aw);
        do_txn(0, 1'b1, 32'hC, 32'h0BAD_0BAD, 4'b0000, 1, 1'b0, aw);
        do_txn(0, 1'b0, 32'hC, 32'd0, 4'h0, 0, 1'b0, aw);

        // Backpressure with a second request already waiting
        do_txn(0, 1'b0, 32'h40, 32'd0, 4'h0, 5, 1'b1, aw);
        do_txn(0, 1'b0, 32'h8, 32'd0, 4'h0, 0, 1'b0, aw2);
        check_val("bp_next_accept_wait", 32'(aw2), 32'd0);

        // Reset while a store to 0x10 is waiting: the store is lost.
        drive_req(0, 1'b1, 1'b1, 32'h10, 32'hCAFE_F00D);
`ifdef DMEM_WSTRB_EN
        b0.req_wstrb = 4'hF;
`endif
        sample(0, rv, rq, rd, re);
        check_val("rstw_pre_ready", 32'(rq), 32'd1);
        @(negedge clk);
        drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        sample(0, rv, rq, rd, re);
        check_val("rstw_in_wait", 32'(rq), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sample(0, rv, rq, rd, re);
        check_val("rstw_req_ready", 32'(rq), 32'd1);
        check_val("rstw_resp_valid", 32'(rv), 32'd0);
        @(negedge clk);
        do_txn(0, 1'b0, 32'h10, 32'd0, 4'h0, 0, 1'b0, aw);

        // LATENCY=1 back-to-back loads
        set_rready(1, 1'b1);
        na = 0; nr = 0; guard = 0;
        drive_req(1, 1'b1, 1'b0, b2b_addr[0], 32'd0);
        while (nr < 4 && guard < 40) begin
            sample(1, rv, rq, rd, re);
            if (rv) begin
                if (exp_q.size() > 0) check_val("b2b_rdata", rd, exp_q.pop_front());
                else                  check_val("b2b_unexpected_resp", 32'(rv), 32'd0);
                nr++;
                if (na < 4) drive_req(1, 1'b1, 1'b0, b2b_addr[na], 32'd0);
                else        drive_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
            end
            if (rq && na < 4) begin
                model_access(1, 1'b0, b2b_addr[na], 32'd0, 4'h0, e_tmp, rd_tmp);
                exp_q.push_back(rd_tmp);
                acc_cyc[na] = cyc;
                na++;
            end
            @(negedge clk);
            guard++;
        end
        set_rready(1, 1'b0);
        drive_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        check_val("b2b_count", 32'(nr), 32'd4);
        for (int i = 1; i < 4; i++)
            check_val("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);

        // Randomized traffic on both instances
        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < 2; i++) begin
                do_txn(i, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                       4'($urandom_range(0, 15)), $urandom_range(0, 3), 1'b0, aw);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
